pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register that replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries a control field and a data field with a valid/ready handshake, a global stall input (driven by memory busy-wait), and a synchronous flush for branch/jump squash. An optional two-entry skid buffer breaks the combinational ready path between stages.

## Interface
- CTRL_W, default 4: width of the control field (write enables, WB select, mem-read enable); zeroed on flush/reset.
- DATA_W, default 101: width of the data field (PC+4, ALU result, memory data, destination register).
- SKID, default 0: 0 selects a single register with combinational IN_READY; 1 selects a two-entry skid buffer with registered IN_READY.
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset (asserted at 0).
- STALL  input  1  freeze the stage (memory busy-wait).
- FLUSH  input  1  synchronous squash of all held entries.
- IN_VALID  input  1  upstream beat valid.
- IN_READY  output  1  stage can accept a beat.
- IN_CTRL  input  CTRL_W  upstream control field.
- IN_DATA  input  DATA_W  upstream data field.
- OUT_VALID  output  1  downstream beat valid.
- OUT_READY  input  1  downstream accepts.
- OUT_CTRL  output  CTRL_W  head-entry control field; all zeros whenever OUT_VALID=0.
- OUT_DATA  output  DATA_W  head-entry data field.
- COUNT  output  2  number of held entries (0..1 for SKID=0, 0..2 for SKID=1).

## Operation
- Accept = IN_VALID & IN_READY. Take = OUT_VALID & OUT_READY.
- STALL=1: IN_READY=0 and OUT_VALID=0 combinationally. No accept and no take occur. All state holds.
- FLUSH=1 (priority over STALL, accept, and take): next edge empties the stage: COUNT→0, OUT_CTRL→0, OUT_DATA holds its value. A beat presented in the same cycle is discarded.
- Head register (main) drives OUT_*. The skid register exists only when SKID=1.
- States: EMPTY (COUNT=0), ONE (COUNT=1), TWO (COUNT=2, SKID=1 only).
  - EMPTY: accept → ONE, main←IN.
  - ONE: accept & take → ONE, main←IN. Accept only → TWO (SKID=1), skid←IN. Take only → EMPTY. Neither → hold.
  - TWO: IN_READY=0. Take → ONE, main←skid. Otherwise hold.
- For SKID=0: IN_READY = !STALL & (!OUT_VALID_int | OUT_READY). The ONE state with accept only cannot occur.
- For SKID=1: IN_READY = !STALL & !(state==TWO). The state term comes from a flop, so there is no path from OUT_READY to IN_READY.
- OUT_VALID = !STALL & (COUNT!=0).
- Ordering is strictly FIFO. No beat is duplicated or dropped except by FLUSH.

## Timing
- Reset (RESET=0, any time, asynchronous): COUNT=0, state EMPTY, OUT_VALID=0, OUT_CTRL=0, OUT_DATA=0, and both registers cleared.
  - On reset: IN_READY=1 when STALL=0.
  - Reset during TWO drops both entries.
- Latency: a beat accepted at edge N is on OUT_* with OUT_VALID=1 after edge N, for one cycle minimum.
- Throughput: one beat per cycle while OUT_READY=1 and STALL=0, in both SKID modes.
- SKID=1 with a full-rate stream and OUT_READY low for one cycle: the skid register absorbs the in-flight beat. IN_READY drops the cycle after entering TWO.
- Deasserting STALL resumes from the held state on the next cycle with no lost or repeated beat.
- FLUSH and STALL asserted together: the flush wins, and the stage is empty after the edge.

## Test plan
- Reset mid-stream:
  - Stimulus: SKID=1, hold the stage in TWO with A=0x11, B=0x22, then pull RESET low between edges.
  - Response: OUT_VALID=0, OUT_CTRL=0, OUT_DATA=0, COUNT=0 immediately, without waiting for a clock edge.
  - After RESET returns high: IN_READY=1.
- Streaming:
  - Stimulus: SKID=0 and SKID=1; IN_DATA=1..8 on 8 consecutive cycles, OUT_READY=1.
  - Response: OUT_DATA=1..8 on consecutive cycles, each one cycle after acceptance, COUNT≤1.
- Backpressure (SKID=1):
  - Stimulus: stream 1..4 with OUT_READY=0 for cycles 2-3.
  - Response: COUNT reaches 2, IN_READY=0 while COUNT=2, output order is 1,2,3,4 with none lost.
- Stall:
  - Stimulus: hold ONE with DATA=0x5A, assert STALL for 3 cycles with IN_VALID=1 and OUT_READY=1.
  - Response: OUT_VALID=0 and IN_READY=0 throughout, COUNT=1. After STALL drops, 0x5A is taken first, then the new beat.
- Flush:
  - Stimulus: COUNT=2, then FLUSH=1 together with STALL=1 and IN_VALID=1 (DATA=0x77).
  - Response: COUNT=0 and OUT_CTRL=0 after the edge. 0x77 never appears on the output.
- Width:
  - Stimulus: CTRL_W=1, DATA_W=32; pass IN_CTRL=1 with IN_DATA=0xFFFFFFFF, then 0x00000000.
  - Response: exact values on the output. OUT_CTRL=0 whenever OUT_VALID=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// pipe_stage_reg : generic pipeline stage register, optional 2-entry skid buffer
// Rev 1.0
// ============================================================================
module pipe_stage_reg #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 101,
  parameter int SKID   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [CTRL_W-1:0] i_in_ctrl,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [CTRL_W-1:0] o_out_ctrl,
  output logic [DATA_W-1:0] o_out_data,
  output logic [1:0]        o_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              r_state;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [DATA_W-1:0]   r_main_data;
  logic [CTRL_W-1:0]   w_skid_ctrl;
  logic [DATA_W-1:0]   w_skid_data;
  logic                w_accept;
  logic                w_take;

  assign o_out_valid = !i_stall && (r_state != ST_EMPTY);
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_take      = o_out_valid && i_out_ready;
  assign o_out_ctrl  = o_out_valid ? r_main_ctrl : '0;
  assign o_out_data  = r_main_data;
  assign o_count     = r_state;

  generate
    if (SKID != 0) begin : g_skid
      logic [CTRL_W-1:0] r_skid_ctrl;
      logic [DATA_W-1:0] r_skid_data;
      logic              w_skid_load;

      // Ready comes only from the state flop, isolating OUT_READY from IN_READY.
      assign o_in_ready  = !i_stall && (r_state != ST_TWO);
      assign w_skid_load = (r_state == ST_ONE) && w_accept && !w_take;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_skid_ctrl <= '0;
          r_skid_data <= '0;
        end else if (i_flush) begin
          r_skid_ctrl <= '0;
        end else if (w_skid_load) begin
          r_skid_ctrl <= i_in_ctrl;
          r_skid_data <= i_in_data;
        end
      end

      assign w_skid_ctrl = r_skid_ctrl;
      assign w_skid_data = r_skid_data;
    end else begin : g_single
      assign o_in_ready  = !i_stall && ((r_state == ST_EMPTY) || i_out_ready);
      assign w_skid_ctrl = '0;
      assign w_skid_data = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_main_ctrl <= '0;
      r_main_data <= '0;
    end else if (i_flush) begin
      // Data is left in place; only the control field is squashed.
      r_state     <= ST_EMPTY;
      r_main_ctrl <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state     <= ST_ONE;
            r_main_ctrl <= i_in_ctrl;
            r_main_data <= i_in_data;
          end
        end
        ST_ONE: begin
          if (w_accept && w_take) begin
            r_main_ctrl <= i_in_ctrl;
            r_main_data <= i_in_data;
          end else if (w_accept && (SKID != 0)) begin
            r_state <= ST_TWO;
          end else if (w_take) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_take) begin
            r_state     <= ST_ONE;
            r_main_ctrl <= w_skid_ctrl;
            r_main_data <= w_skid_data;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// tb_pipe_stage_reg : three DUT variants (SKID=0, SKID=1, narrow SKID=0) vs queue model
// Rev 1.0
// ============================================================================
module tb_pipe_stage_reg;

  localparam int CW = 4;
  localparam int DW = 101;
  localparam int EW = CW + DW;
  localparam int SK [3] = '{0, 1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          stall, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          rdy0, rdy1, rdy2, v0, v1, v2;
  logic [1:0]    cnt0, cnt1, cnt2;
  logic [CW-1:0] oc0, oc1;
  logic [0:0]    oc2;
  logic [DW-1:0] od0, od1;
  logic [31:0]   od2;

  int nvec = 0;
  int nerr = 0;

  // Reference model: per DUT an ordered list of held beats plus the last head data.
  logic [EW-1:0] mq [3][2];
  int            msz [3];
  logic [DW-1:0] hd [3];

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u0 (
    .clk(clk), .rst_n(rst_n), .i_stall(stall), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(rdy0), .i_in_ctrl(in_ctrl), .i_in_data(in_data),
    .o_out_valid(v0), .i_out_ready(out_ready), .o_out_ctrl(oc0), .o_out_data(od0),
    .o_count(cnt0));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u1 (
    .clk(clk), .rst_n(rst_n), .i_stall(stall), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(rdy1), .i_in_ctrl(in_ctrl), .i_in_data(in_data),
    .o_out_valid(v1), .i_out_ready(out_ready), .o_out_ctrl(oc1), .o_out_data(od1),
    .o_count(cnt1));

  pipe_stage_reg #(.CTRL_W(1), .DATA_W(32), .SKID(0)) u2 (
    .clk(clk), .rst_n(rst_n), .i_stall(stall), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(rdy2), .i_in_ctrl(in_ctrl[0:0]), .i_in_data(in_data[31:0]),
    .o_out_valid(v2), .i_out_ready(out_ready), .o_out_ctrl(oc2), .o_out_data(od2),
    .o_count(cnt2));

  function automatic logic [CW-1:0] cmask(int k);
    return (k == 2) ? 4'h1 : 4'hF;
  endfunction

  function automatic logic [DW-1:0] dmask(int k);
    logic [DW-1:0] m;
    m = '1;
    if (k == 2) m = {{(DW-32){1'b0}}, 32'hFFFF_FFFF};
    return m;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      msz[k] = 0;
      hd[k]  = '0;
    end
  endtask

  // One clock cycle: compare every DUT against the model, then advance both.
  task automatic step();
    logic          ev, er, av, ar;
    logic [CW-1:0] ec, ac;
    logic [DW-1:0] ed, ad;
    logic [1:0]    an;
    logic          acc [3];
    logic          tk [3];
    #1;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin av = v0; ar = rdy0; ac = oc0; ad = od0; an = cnt0; end
        1: begin av = v1; ar = rdy1; ac = oc1; ad = od1; an = cnt1; end
        default: begin av = v2; ar = rdy2; ac = {3'b0, oc2}; ad = {{(DW-32){1'b0}}, od2}; an = cnt2; end
      endcase
      ev = !stall && (msz[k] > 0);
      er = !stall && ((SK[k] != 0) ? (msz[k] < 2) : ((msz[k] == 0) || out_ready));
      ec = ev ? mq[k][0][EW-1:DW] : '0;
      ed = (msz[k] > 0) ? mq[k][0][DW-1:0] : hd[k];
      nvec += 5;
      if (av !== ev) begin nerr++; $display("FAIL out_valid dut%0d t=%0t got %0b want %0b", k, $time, av, ev); end
      if (ar !== er) begin nerr++; $display("FAIL in_ready dut%0d t=%0t got %0b want %0b", k, $time, ar, er); end
      if (ac !== ec) begin nerr++; $display("FAIL out_ctrl dut%0d t=%0t got %h want %h", k, $time, ac, ec); end
      if (ad !== ed) begin nerr++; $display("FAIL out_data dut%0d t=%0t got %h want %h", k, $time, ad, ed); end
      if (an !== 2'(msz[k])) begin nerr++; $display("FAIL count dut%0d t=%0t got %0d want %0d", k, $time, an, msz[k]); end
      acc[k] = in_valid && er;
      tk[k]  = ev && out_ready;
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (flush) begin
        msz[k] = 0;
      end else begin
        if (tk[k]) begin
          mq[k][0] = mq[k][1];
          msz[k]--;
        end
        if (acc[k]) begin
          mq[k][msz[k]] = {in_ctrl & cmask(k), in_data & dmask(k)};
          msz[k]++;
        end
      end
      if (msz[k] > 0) hd[k] = mq[k][0][DW-1:0];
    end
    #1;
  endtask

  task automatic do_reset();
    stall = 0; flush = 0; in_valid = 0; out_ready = 0; in_ctrl = '0; in_data = '0;
    rst_n = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    nvec += 4;
    if (cnt0 !== 2'd0 || cnt1 !== 2'd0 || cnt2 !== 2'd0) begin nerr++; $display("FAIL reset_count got %0d/%0d/%0d want 0", cnt0, cnt1, cnt2); end
    if (v0 !== 1'b0 || v1 !== 1'b0 || v2 !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b%b%b want 000", v0, v1, v2); end
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1 || rdy2 !== 1'b1) begin nerr++; $display("FAIL reset_ready got %b%b%b want 111", rdy0, rdy1, rdy2); end
    if (od0 !== '0 || od1 !== '0 || od2 !== '0) begin nerr++; $display("FAIL reset_data got %h/%h/%h want 0", od0, od1, od2); end
    // Fill the skid variant, then reset between edges.
    in_valid = 1; out_ready = 0; in_ctrl = 4'h3; in_data = DW'(8'h11);
    step();
    in_data = DW'(8'h22);
    step();
    nvec++;
    if (cnt1 !== 2'd2 || rdy1 !== 1'b0) begin nerr++; $display("FAIL fill_two got cnt=%0d rdy=%b want cnt=2 rdy=0", cnt1, rdy1); end
    #1 rst_n = 0;
    model_clear();
    #1;
    nvec += 4;
    if (v1 !== 1'b0) begin nerr++; $display("FAIL async_valid got %b want 0", v1); end
    if (oc1 !== '0) begin nerr++; $display("FAIL async_ctrl got %h want 0", oc1); end
    if (od1 !== '0) begin nerr++; $display("FAIL async_data got %h want 0", od1); end
    if (cnt1 !== 2'd0) begin nerr++; $display("FAIL async_count got %0d want 0", cnt1); end
    in_valid = 0;
    #1 rst_n = 1;
    #1;
    nvec++;
    if (rdy1 !== 1'b1) begin nerr++; $display("FAIL post_reset_ready got %b want 1", rdy1); end
    step();
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1; in_ctrl = 4'(i); in_data = DW'(i);
      step();
      nvec += 2;
      if (cnt0 > 2'd1 || cnt1 > 2'd1) begin nerr++; $display("FAIL stream_count beat %0d got %0d/%0d want <=1", i, cnt0, cnt1); end
      if (od0 !== DW'(i) || od1 !== DW'(i) || !v0 || !v1) begin
        nerr++; $display("FAIL stream_data beat %0d got %0h/%0h want %0h", i, od0, od1, i);
      end
    end
    in_valid = 0;
    step();
    step();
  endtask

  task automatic test_back_to_back();
    int d;
    int maxc;
    int got[$];
    logic adv;
    do_reset();
    d = 1; maxc = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      out_ready = !(cyc == 2 || cyc == 3);
      in_valid  = (d <= 4);
      in_data   = DW'(d);
      in_ctrl   = 4'(d);
      #1;
      if (v1 && out_ready) got.push_back(int'(od1[7:0]));
      if (int'(cnt1) > maxc) maxc = int'(cnt1);
      if (cnt1 == 2'd2) begin
        nvec++;
        if (rdy1 !== 1'b0) begin nerr++; $display("FAIL bp_ready_at_two cyc %0d got %b want 0", cyc, rdy1); end
      end
      adv = in_valid && rdy1;
      step();
      if (adv) d++;
    end
    nvec += 2;
    if (maxc != 2) begin nerr++; $display("FAIL bp_max_count got %0d want 2", maxc); end
    if (got.size() != 4) begin nerr++; $display("FAIL bp_beats got %0d want 4", got.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        nvec++;
        if (got[i] != i + 1) begin nerr++; $display("FAIL bp_order idx %0d got %0d want %0d", i, got[i], i + 1); end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    in_valid = 1; out_ready = 0; in_data = DW'(8'h5A); in_ctrl = 4'h2;
    step();
    in_data = DW'(8'h5B); stall = 1; out_ready = 1;
    repeat (3) begin
      #1;
      nvec += 3;
      if (v0 !== 1'b0 || v1 !== 1'b0) begin nerr++; $display("FAIL stall_valid got %b%b want 00", v0, v1); end
      if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin nerr++; $display("FAIL stall_ready got %b%b want 00", rdy0, rdy1); end
      if (cnt0 !== 2'd1 || cnt1 !== 2'd1) begin nerr++; $display("FAIL stall_count got %0d/%0d want 1", cnt0, cnt1); end
      step();
    end
    stall = 0;
    #1;
    nvec++;
    if (!v1 || od1 !== DW'(8'h5A)) begin nerr++; $display("FAIL stall_resume_first got v=%b %h want v=1 5a", v1, od1); end
    step();
    nvec++;
    if (!v1 || od1 !== DW'(8'h5B)) begin nerr++; $display("FAIL stall_resume_next got v=%b %h want v=1 5b", v1, od1); end
    in_valid = 0;
    step();
    step();
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1; out_ready = 0; in_ctrl = 4'h5; in_data = DW'(8'h0A);
    step();
    in_data = DW'(8'h0B);
    step();
    nvec++;
    if (cnt1 !== 2'd2) begin nerr++; $display("FAIL flush_pre_count got %0d want 2", cnt1); end
    flush = 1; stall = 1; in_valid = 1; in_data = DW'(8'h77);
    step();
    nvec += 2;
    if (cnt0 !== 2'd0 || cnt1 !== 2'd0 || cnt2 !== 2'd0) begin nerr++; $display("FAIL flush_count got %0d/%0d/%0d want 0", cnt0, cnt1, cnt2); end
    if (oc1 !== '0 || oc0 !== '0) begin nerr++; $display("FAIL flush_ctrl got %h/%h want 0", oc0, oc1); end
    flush = 0; stall = 0; in_valid = 0; out_ready = 1;
    repeat (3) begin
      #1;
      nvec++;
      if (v1 !== 1'b0 || (v1 && od1 === DW'(8'h77))) begin nerr++; $display("FAIL flush_leak got v=%b %h want v=0", v1, od1); end
      step();
    end
  endtask

  task automatic test_width();
    do_reset();
    out_ready = 1; in_valid = 1; in_ctrl = 4'hF; in_data = {{(DW-32){1'b1}}, 32'hFFFF_FFFF};
    step();
    nvec++;
    if (!v2 || oc2 !== 1'b1 || od2 !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL width_ones got v=%b c=%b d=%h want 1 1 ffffffff", v2, oc2, od2); end
    in_ctrl = 4'h1; in_data = '0;
    step();
    nvec++;
    if (!v2 || oc2 !== 1'b1 || od2 !== 32'h0) begin nerr++; $display("FAIL width_zeros got v=%b c=%b d=%h want 1 1 0", v2, oc2, od2); end
    in_valid = 0; stall = 1;
    #1;
    nvec++;
    if (v2 !== 1'b0 || oc2 !== 1'b0) begin nerr++; $display("FAIL width_stall_ctrl got v=%b c=%b want 0 0", v2, oc2); end
    step();
    stall = 0;
    step();
    nvec++;
    if (v2 !== 1'b0 || oc2 !== 1'b0) begin nerr++; $display("FAIL width_idle_ctrl got v=%b c=%b want 0 0", v2, oc2); end
  endtask

  task automatic test_random();
    logic [127:0] r;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      stall     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_ctrl   = 4'($urandom_range(0, 15));
      r         = {$urandom, $urandom, $urandom, $urandom};
      in_data   = r[DW-1:0];
      step();
    end
    stall = 0; flush = 0; in_valid = 0; out_ready = 1;
    repeat (3) step();
  endtask

  initial begin
    rst_n = 0;
    test_reset();
    test_streaming();
    test_back_to_back();
    test_stall();
    test_flush();
    test_width();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
